// File: rtl/gate_arbiter.sv
// gate_arbiter
//   Arbiter and sequencer for one shared bitwise AND unit. One of NREQ
//   requesters is picked, its operands are captured, and f = a & b is
//   computed and returned with the winner's index. The return uses a
//   valid/ready handshake.
//
//   Sequence: IDLE -(grant)-> EVAL -> RESULT -(f_ready)-> IDLE.
//   With f_ready held high, each service takes 3 cycles.
//
// Configuration macro:
//   GATE_ARB_FIXED_PRIO_EN  defined     : lowest-index active request wins
//                           not defined : round-robin starting after last_ptr
//
// Ports:
//   clk      in   single rising-edge clock
//   rst      in   synchronous active-high reset
//   req      in   [NREQ]        level request per requester
//   a_in     in   [NREQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   b_in     in   [NREQ*WIDTH]  operand B, same packing
//   gnt      out  [NREQ]        registered one-hot grant pulse (one cycle)
//   f_out    out  [WIDTH]       a & b of the granted requester
//   f_id     out  [clog2(NREQ)] index of the requester owning f_out
//   f_valid  out  result valid
//   f_ready  in   consumer accepts result
//   busy     out  high from grant until result accepted
module gate_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     a_in,
  input  logic [NREQ*WIDTH-1:0]     b_in,
  output logic [NREQ-1:0]           gnt,
  output logic [WIDTH-1:0]          f_out,
  output logic [$clog2(NREQ)-1:0]   f_id,
  output logic                      f_valid,
  input  logic                      f_ready,
  output logic                      busy
);

  localparam int ID_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   last_ptr_reg, last_ptr_next;
  logic [ID_W-1:0]   win_reg, win_next;
  logic [WIDTH-1:0]  a_cap_reg, a_cap_next;
  logic [WIDTH-1:0]  b_cap_reg, b_cap_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic [WIDTH-1:0]  f_out_reg, f_out_next;
  logic [ID_W-1:0]   f_id_reg, f_id_next;
  logic              f_valid_reg, f_valid_next;
  logic              busy_reg, busy_next;

  logic [WIDTH-1:0]  a_arr [NREQ];
  logic [WIDTH-1:0]  b_arr [NREQ];
  logic [ID_W-1:0]   rr_cand [NREQ];
  logic [ID_W-1:0]   win_idx;

  // Unpack operands. rr_cand[k] is the k-th index visited by the
  // round-robin search, which starts just after last_ptr.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign a_arr[gi]   = a_in[gi*WIDTH +: WIDTH];
    assign b_arr[gi]   = b_in[gi*WIDTH +: WIDTH];
    assign rr_cand[gi] = ID_W'((int'(last_ptr_reg) + gi + 1) % NREQ);
  end

  // Winner search. Scanning from the far end means the last hit is the
  // nearest one, so no break is needed.
  always_comb begin
    win_idx = '0;
`ifdef GATE_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) win_idx = ID_W'(i);
    end
`else
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[rr_cand[k]]) win_idx = rr_cand[k];
    end
`endif
  end

  always_comb begin
    state_next    = state_reg;
    last_ptr_next = last_ptr_reg;
    win_next      = win_reg;
    a_cap_next    = a_cap_reg;
    b_cap_next    = b_cap_reg;
    gnt_next      = '0;          // the grant is a single-cycle pulse
    f_out_next    = f_out_reg;
    f_id_next     = f_id_reg;
    f_valid_next  = f_valid_reg;
    busy_next     = busy_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          win_next      = win_idx;
          last_ptr_next = win_idx;
          a_cap_next    = a_arr[win_idx];
          b_cap_next    = b_arr[win_idx];
          gnt_next      = NREQ'(1) << win_idx;
          busy_next     = 1'b1;
          state_next    = EVAL;
        end
      end
      EVAL: begin
        f_out_next   = a_cap_reg & b_cap_reg;
        f_id_next    = win_reg;
        f_valid_next = 1'b1;
        state_next   = RESULT;
      end
      RESULT: begin
        if (f_ready) begin
          f_valid_next = 1'b0;
          busy_next    = 1'b0;
          state_next   = IDLE;
        end
      end
      default: begin
        f_valid_next = 1'b0;
        busy_next    = 1'b0;
        state_next   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      last_ptr_reg <= ID_W'(NREQ - 1);
      win_reg      <= '0;
      a_cap_reg    <= '0;
      b_cap_reg    <= '0;
      gnt_reg      <= '0;
      f_out_reg    <= '0;
      f_id_reg     <= '0;
      f_valid_reg  <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      last_ptr_reg <= last_ptr_next;
      win_reg      <= win_next;
      a_cap_reg    <= a_cap_next;
      b_cap_reg    <= b_cap_next;
      gnt_reg      <= gnt_next;
      f_out_reg    <= f_out_next;
      f_id_reg     <= f_id_next;
      f_valid_reg  <= f_valid_next;
      busy_reg     <= busy_next;
    end
  end

  assign gnt     = gnt_reg;
  assign f_out   = f_out_reg;
  assign f_id    = f_id_reg;
  assign f_valid = f_valid_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_gate_arbiter.sv
// Directed testbench for gate_arbiter (NREQ=4, WIDTH=8).
// Inputs are driven and outputs sampled on the falling clock edge.
// Honors GATE_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_gate_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [3:0]  gnt;
  logic [7:0]  f_out;
  logic [1:0]  f_id;
  logic        f_valid;
  logic        f_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  gate_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .a_in    (a_in),
    .b_in    (b_in),
    .gnt     (gnt),
    .f_out   (f_out),
    .f_id    (f_id),
    .f_valid (f_valid),
    .f_ready (f_ready),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full service with f_ready high: grant, result, accept.
  task automatic serve(input string tag, input logic [3:0] exp_gnt,
                       input logic [7:0] exp_f, input logic [1:0] exp_id);
    step();
    check_eq({tag, ".gnt"},   32'(gnt),     32'(exp_gnt));
    check_eq({tag, ".busy"},  32'(busy),    32'd1);
    step();
    check_eq({tag, ".gnt0"},  32'(gnt),     32'd0);
    check_eq({tag, ".valid"}, 32'(f_valid), 32'd1);
    check_eq({tag, ".f"},     32'(f_out),   32'(exp_f));
    check_eq({tag, ".id"},    32'(f_id),    32'(exp_id));
    step();
    check_eq({tag, ".done"},  32'(f_valid), 32'd0);
    check_eq({tag, ".idle"},  32'(busy),    32'd0);
    $display("%s: gnt=%b f_out=%h f_id=%0d", tag, exp_gnt, exp_f, exp_id);
  endtask

  // Slot operands used from test 3 on. Expected f: 0:A5 1:50 2:0C 3:0F.
  localparam logic [31:0] A_TAB = {8'h0F, 8'h3C, 8'hF0, 8'hFF};
  localparam logic [31:0] B_TAB = {8'hFF, 8'h0F, 8'h55, 8'hA5};

  initial begin
    logic [7:0] f_tab [4];
    int         k;
    f_tab[0] = 8'hA5; f_tab[1] = 8'h50; f_tab[2] = 8'h0C; f_tab[3] = 8'h0F;

    rst = 1'b1; req = 4'b1111; a_in = '0; b_in = '0; f_ready = 1'b1;
    @(negedge clk);

    // 1. Reset with all requests high
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("rst.gnt",   32'(gnt),     32'd0);
      check_eq("rst.valid", 32'(f_valid), 32'd0);
      check_eq("rst.f",     32'(f_out),   32'd0);
      check_eq("rst.id",    32'(f_id),    32'd0);
      check_eq("rst.busy",  32'(busy),    32'd0);
    end
    $display("reset: outputs cleared");
    rst = 1'b0; req = 4'b0000;

    // 2. Single request from requester 2
    req = 4'b0100; a_in = 32'h00F0_0000; b_in = 32'h003C_0000;
    step();
    check_eq("single.gnt",   32'(gnt),     32'h4);
    check_eq("single.valid", 32'(f_valid), 32'd0);
    req = 4'b0000;
    a_in = 32'h0000_0000;                 // changes after grant must not matter
    step();
    check_eq("single.gnt0",  32'(gnt),     32'd0);
    check_eq("single.valid1", 32'(f_valid), 32'd1);
    check_eq("single.f",     32'(f_out),   32'h30);
    check_eq("single.id",    32'(f_id),    32'd2);
    step();
    check_eq("single.drop",  32'(f_valid), 32'd0);
    check_eq("single.hold",  32'(f_out),   32'h30);
    $display("single: gnt=0100 f_out=30 f_id=2");

    // 3. Fairness with all requests held (fresh pointer after reset)
    rst = 1'b1; step(); rst = 1'b0;
    a_in = A_TAB; b_in = B_TAB; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
`ifdef GATE_ARB_FIXED_PRIO_EN
      k = 0;
`else
      k = i % 4;
`endif
      serve("fair", 4'b0001 << k, f_tab[k], 2'(k));
    end
    req = 4'b0000;

    // 4. Backpressure on requester 0 (last_ptr is 0, only req0 active)
    a_in = 32'h0000_00AA; b_in = 32'h0000_00FF; req = 4'b0001; f_ready = 1'b0;
    step();
    check_eq("bp.gnt", 32'(gnt), 32'h1);
    step();
    check_eq("bp.valid", 32'(f_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp.valid_hold", 32'(f_valid), 32'd1);
      check_eq("bp.f_hold",     32'(f_out),   32'hAA);
      check_eq("bp.busy_hold",  32'(busy),    32'd1);
      check_eq("bp.no_gnt",     32'(gnt),     32'd0);
    end
    f_ready = 1'b1; req = 4'b0000;
    step();
    check_eq("bp.release", 32'(f_valid), 32'd0);
    check_eq("bp.busy0",   32'(busy),    32'd0);
    $display("backpressure: f_out=AA held 5 cycles");

    // 5. Reset during EVAL
    a_in = A_TAB; b_in = B_TAB; req = 4'b1000;
    step();
    check_eq("rsteval.gnt", 32'(gnt), 32'h8);
    rst = 1'b1; req = 4'b0000;
    step();
    check_eq("rsteval.valid", 32'(f_valid), 32'd0);
    check_eq("rsteval.busy",  32'(busy),    32'd0);
    rst = 1'b0;
    step();
    check_eq("rsteval.valid2", 32'(f_valid), 32'd0);
    req = 4'b1001;
    step();
    check_eq("rsteval.next_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    step();
    check_eq("rsteval.f", 32'(f_out), 32'hA5);
    step();
    $display("reset-in-eval: req3 dropped, next gnt=0001");

    // 6. Pointer wrap: last grant 3, then 1010 held
    req = 4'b1000;
    serve("wrap.pre", 4'b1000, 8'h0F, 2'd3);
    req = 4'b1010;
`ifdef GATE_ARB_FIXED_PRIO_EN
    serve("wrap", 4'b0010, 8'h50, 2'd1);
    serve("wrap", 4'b0010, 8'h50, 2'd1);
    serve("wrap", 4'b0010, 8'h50, 2'd1);
`else
    serve("wrap", 4'b0010, 8'h50, 2'd1);
    serve("wrap", 4'b1000, 8'h0F, 2'd3);
    serve("wrap", 4'b0010, 8'h50, 2'd1);
`endif
    req = 4'b0000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
